// File: rtl/fp_transfer_pipe.sv
// Pipelined int/fp register transfer and FCLASS unit with NaN-boxing, tag passthrough and an
// elastic valid/ready pipeline. Results are computed at acceptance; later stages only delay.
module fp_transfer_pipe #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned TAG_W      = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] INPUT,
  input  logic              SP_DP,
  input  logic [2:0]        OPERATION,
  input  logic [TAG_W-1:0]  IN_TAG,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUTPUT,
  output logic [TAG_W-1:0]  OUT_TAG,
  output logic              OUT_ILLEGAL,
  output logic              BUSY
);

  localparam logic [2:0] OpMovIntFp = 3'b000;
  localparam logic [2:0] OpMovFpInt = 3'b001;
  localparam logic [2:0] OpFclass   = 3'b100;
  localparam bit         HasDp      = (DATA_W == 64);

  // One-hot class: -inf, -norm, -sub, -0, +0, +sub, +norm, +inf, sNaN, qNaN.
  function automatic logic [9:0] fclass(input logic sign, input logic exp_ones,
                                        input logic exp_zero, input logic man_zero,
                                        input logic man_msb);
    logic [9:0] c;
    c = '0;
    if (exp_ones) begin
      if (man_zero)     c[sign ? 0 : 7] = 1'b1;
      else if (man_msb) c[9] = 1'b1;
      else              c[8] = 1'b1;
    end else if (exp_zero) begin
      if (man_zero) c[sign ? 3 : 4] = 1'b1;
      else          c[sign ? 2 : 5] = 1'b1;
    end else begin
      c[sign ? 1 : 6] = 1'b1;
    end
    return c;
  endfunction

  logic [9:0]        class_sp;
  logic [9:0]        class_dp;
  logic              sp_boxed;
  logic [DATA_W-1:0] mov_to_fp_sp;
  logic [DATA_W-1:0] mov_to_int_sp;

  assign class_sp = fclass(INPUT[31], &INPUT[30:23], ~|INPUT[30:23], ~|INPUT[22:0], INPUT[22]);

  generate
    if (DATA_W == 64) begin : g_dp
      assign class_dp      = fclass(INPUT[63], &INPUT[62:52], ~|INPUT[62:52], ~|INPUT[51:0],
                                    INPUT[51]);
      assign sp_boxed      = &INPUT[63:32];
      assign mov_to_fp_sp  = {32'hFFFF_FFFF, INPUT[31:0]};
      assign mov_to_int_sp = {{32{INPUT[31]}}, INPUT[31:0]};
    end else begin : g_sp
      // 32-bit datapath: no boxing, and DP ops are flagged illegal before class_dp is used.
      assign class_dp      = '0;
      assign sp_boxed      = 1'b1;
      assign mov_to_fp_sp  = INPUT;
      assign mov_to_int_sp = INPUT;
    end
  endgenerate

  logic [DATA_W-1:0] res_data;
  logic              res_illegal;

  always_comb begin
    res_data    = '0;
    res_illegal = 1'b0;
    if (SP_DP && !HasDp) begin
      res_illegal = 1'b1;
    end else begin
      case (OPERATION)
        OpMovIntFp: res_data = SP_DP ? INPUT : mov_to_fp_sp;
        OpMovFpInt: res_data = SP_DP ? INPUT : mov_to_int_sp;
        OpFclass:   res_data[9:0] = SP_DP ? class_dp : (sp_boxed ? class_sp : 10'h200);
        default:    res_illegal = 1'b1;
      endcase
    end
  end

  logic [PIPE_DEPTH-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]     data_q [PIPE_DEPTH];
  logic [DATA_W-1:0]     data_d [PIPE_DEPTH];
  logic [TAG_W-1:0]      tag_q  [PIPE_DEPTH];
  logic [TAG_W-1:0]      tag_d  [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] ill_q, ill_d;
  logic [PIPE_DEPTH-1:0] advance;

  // A stage advances if it or any stage downstream of it has a hole, or the sink takes data.
  always_comb begin
    logic run;
    advance = '0;
    run     = OUT_READY;
    for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
      run        = run | ~valid_q[k];
      advance[k] = run;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    ill_d   = ill_q;
    if (advance[0]) begin
      valid_d[0] = IN_VALID;
      if (IN_VALID) begin
        data_d[0] = res_data;
        tag_d[0]  = IN_TAG;
        ill_d[0]  = res_illegal;
      end
    end
    for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
      if (advance[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
          tag_d[k]  = tag_q[k-1];
          ill_d[k]  = ill_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      ill_q   <= '0;
      for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ill_q   <= ill_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign IN_READY    = ~valid_q[0] | advance[0];
  assign OUT_VALID   = valid_q[PIPE_DEPTH-1];
  assign OUTPUT      = data_q[PIPE_DEPTH-1];
  assign OUT_TAG     = tag_q[PIPE_DEPTH-1];
  assign OUT_ILLEGAL = ill_q[PIPE_DEPTH-1];
  assign BUSY        = |valid_q;

endmodule

// File: tb/tb_fp_transfer_pipe.sv
// Scoreboard bench for fp_transfer_pipe: directed cases plus randomized traffic with random
// backpressure, checked against a behavioural model of the transfer/classify rules.
module tb_fp_transfer_pipe;

  localparam int DataW = 64;
  localparam int Depth = 2;
  localparam int TagW  = 5;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             IN_VALID;
  logic             IN_READY;
  logic [DataW-1:0] INPUT;
  logic             SP_DP;
  logic [2:0]       OPERATION;
  logic [TagW-1:0]  IN_TAG;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [DataW-1:0] OUTPUT;
  logic [TagW-1:0]  OUT_TAG;
  logic             OUT_ILLEGAL;
  logic             BUSY;

  fp_transfer_pipe #(
    .DATA_W    (DataW),
    .PIPE_DEPTH(Depth),
    .TAG_W     (TagW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .INPUT      (INPUT),
    .SP_DP      (SP_DP),
    .OPERATION  (OPERATION),
    .IN_TAG     (IN_TAG),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUTPUT     (OUTPUT),
    .OUT_TAG    (OUT_TAG),
    .OUT_ILLEGAL(OUT_ILLEGAL),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        ill;
    int          acc_cyc;
    bit          chk_lat;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    rand_ready = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: {illegal, result} straight from the op definitions.
  function automatic logic [64:0] model(input logic [63:0] x, input bit dp, input logic [2:0] op);
    longint unsigned u, frac;
    int ew, fw, e, emax, idx;
    bit s;
    case (op)
      3'b000: return {1'b0, dp ? x : {32'hFFFF_FFFF, x[31:0]}};
      3'b001: return {1'b0, dp ? x : 64'($signed(x[31:0]))};
      3'b100: begin
        ew   = dp ? 11 : 8;
        fw   = dp ? 52 : 23;
        u    = dp ? x : {32'd0, x[31:0]};
        emax = (1 << ew) - 1;
        e    = int'((u >> fw) & 64'(emax));
        frac = u & ((64'd1 << fw) - 1);
        s    = u[fw+ew];
        if (!dp && x[63:32] != 32'hFFFF_FFFF) idx = 9;
        else if (e == emax) idx = (frac == 0) ? (s ? 0 : 7) : (frac[fw-1] ? 9 : 8);
        else if (e == 0)    idx = (frac == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
        else                idx = s ? 1 : 6;
        return {1'b0, 64'd1 << idx};
      end
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    if (rand_ready) OUT_READY = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [63:0] d, input bit dp, input logic [2:0] op,
                       input logic [4:0] tag, input bit use_exp, input logic [63:0] exp_d,
                       input bit exp_ill, input bit chk_lat);
    item_t it;
    logic [64:0] m;
    bit acc;
    IN_VALID  = 1'b1;
    INPUT     = d;
    SP_DP     = dp;
    OPERATION = op;
    IN_TAG    = tag;
    acc       = 0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge CLK);
      if (IN_READY) begin
        m          = model(d, dp, op);
        it.data    = use_exp ? exp_d : m[63:0];
        it.ill     = use_exp ? exp_ill : m[64];
        it.tag     = tag;
        it.acc_cyc = cyc;
        it.chk_lat = chk_lat;
        sb.push_back(it);
        acc = 1;
      end
      step();
    end
    IN_VALID = 1'b0;
    check("accept_in_time", 64'(acc), 64'd1);
  endtask

  task automatic issue_x(input logic [63:0] d, input bit dp, input logic [2:0] op,
                         input logic [4:0] tag, input logic [63:0] exp_d, input bit exp_ill);
    issue(d, dp, op, tag, 1, exp_d, exp_ill, 1);
  endtask

  task automatic issue_m(input logic [63:0] d, input bit dp, input logic [2:0] op,
                         input logic [4:0] tag);
    issue(d, dp, op, tag, 0, '0, 0, 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) step();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops on every output handshake, and checks outputs hold while stalled.
  bit          prev_stall = 0;
  logic [63:0] prev_data;
  logic [4:0]  prev_tag;
  logic        prev_ill;

  always @(negedge CLK) begin
    item_t it;
    if (RESET) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {OUT_VALID, OUT_ILLEGAL, OUT_TAG, OUTPUT[56:0]},
              {1'b1, prev_ill, prev_tag, prev_data[56:0]});
        check("stall_hold_hi", 64'(OUTPUT[63:57]), 64'(prev_data[63:57]));
      end
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(OUT_TAG), 64'hDEAD);
        end else begin
          it = sb.pop_front();
          check("out_data", OUTPUT, it.data);
          check("out_tag", 64'(OUT_TAG), 64'(it.tag));
          check("out_illegal", 64'(OUT_ILLEGAL), 64'(it.ill));
          if (it.chk_lat) check("latency", 64'(cyc - it.acc_cyc), 64'(Depth));
        end
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = OUTPUT;
      prev_tag   = OUT_TAG;
      prev_ill   = OUT_ILLEGAL;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [2:0]  op;
    int          k;
    bit          dp;

    RESET = 1'b1; IN_VALID = 1'b0; INPUT = '0; SP_DP = 1'b0;
    OPERATION = 3'b000; IN_TAG = '0; OUT_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    @(negedge CLK);
    check("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_output", OUTPUT, 64'd0);
    check("rst_out_tag", 64'(OUT_TAG), 64'd0);
    check("rst_out_illegal", 64'(OUT_ILLEGAL), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_in_ready", 64'(IN_READY), 64'd1);
    step();
    OUT_READY = 1'b1;

    // FCLASS SP: boxed +1.0 then an improperly boxed operand.
    issue_x(64'hFFFF_FFFF_3F80_0000, 0, 3'b100, 5'd1, 64'h040, 0);
    issue_x(64'h0000_0000_3F80_0000, 0, 3'b100, 5'd2, 64'h200, 0);
    drain();

    // FCLASS DP back-to-back; latency check forces consecutive results.
    issue_x(64'hFFF0_0000_0000_0000, 1, 3'b100, 5'd3, 64'h001, 0);
    issue_x(64'h8000_0000_0000_0000, 1, 3'b100, 5'd4, 64'h008, 0);
    issue_x(64'h0000_0000_0000_0001, 1, 3'b100, 5'd5, 64'h020, 0);
    issue_x(64'h7FF0_0000_0000_0001, 1, 3'b100, 5'd6, 64'h100, 0);
    issue_x(64'h7FF8_0000_0000_0000, 1, 3'b100, 5'd7, 64'h200, 0);
    drain();

    // Moves.
    issue_x(64'h0000_0000_1234_5678, 0, 3'b000, 5'd8, 64'hFFFF_FFFF_1234_5678, 0);
    issue_x(64'hFFFF_FFFF_8000_0001, 0, 3'b001, 5'd9, 64'hFFFF_FFFF_8000_0001, 0);
    issue_x(64'hFFFF_FFFF_7FFF_FFFF, 0, 3'b001, 5'd10, 64'h0000_0000_7FFF_FFFF, 0);
    issue_x(64'h0123_4567_89AB_CDEF, 1, 3'b000, 5'd11, 64'h0123_4567_89AB_CDEF, 0);
    issue_x(64'hFEDC_BA98_7654_3210, 1, 3'b001, 5'd12, 64'hFEDC_BA98_7654_3210, 0);
    drain();

    // Backpressure: two ops fill the pipe, the third must wait.
    OUT_READY = 1'b0;
    issue_m(64'hFFFF_FFFF_0000_0001, 0, 3'b000, 5'd1);
    issue_m(64'hFFFF_FFFF_0000_0002, 0, 3'b000, 5'd2);
    IN_VALID = 1'b1; INPUT = 64'hFFFF_FFFF_0000_0003; SP_DP = 1'b0;
    OPERATION = 3'b000; IN_TAG = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp_in_ready", 64'(IN_READY), 64'd0);
      check("bp_head_tag", {OUT_VALID, 58'd0, OUT_TAG}, {1'b1, 58'd0, 5'd1});
      step();
    end
    OUT_READY = 1'b1;
    fork
      issue_m(64'hFFFF_FFFF_0000_0003, 0, 3'b000, 5'd3);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge CLK);
          check("bp_release_order", {OUT_VALID, 58'd0, OUT_TAG}, {1'b1, 58'd0, 5'(i + 1)});
        end
      end
    join
    drain();

    // Illegal opcodes.
    issue_x(64'hFFFF_FFFF_3F80_0000, 0, 3'b011, 5'd7, 64'd0, 1);
    issue_x(64'h7FF8_0000_0000_0000, 1, 3'b111, 5'd13, 64'd0, 1);
    drain();

    // Reset with two entries in flight.
    OUT_READY = 1'b0;
    issue_m(64'h1, 1, 3'b000, 5'd20);
    issue_m(64'h2, 1, 3'b000, 5'd21);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    sb.delete();
    @(negedge CLK);
    check("rst_flight_out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_flight_busy", 64'(BUSY), 64'd0);
    check("rst_flight_in_ready", 64'(IN_READY), 64'd1);
    step();
    OUT_READY = 1'b1;
    repeat (5) step();

    // Randomized traffic with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      d  = {$urandom(), $urandom()};
      dp = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 7))
        0: d[62:52] = '1;
        1: d[62:52] = '0;
        2: d[30:23] = '1;
        3: d[30:23] = '0;
        4: begin d[30:23] = '1; d[22:0] = '0; end
        5: begin d[62:52] = '1; d[51:0] = '0; end
        default: ;
      endcase
      if (!dp && $urandom_range(0, 3) != 0) d[63:32] = '1;
      k  = $urandom_range(0, 9);
      op = (k < 3) ? 3'b000 : (k < 6) ? 3'b001 : (k < 9) ? 3'b100 : 3'($urandom_range(0, 7));
      issue_m(d, dp, op, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 4) == 0) step();
    end
    rand_ready = 0;
    OUT_READY = 1'b1;
    drain();
    step();
    check("final_busy", 64'(BUSY), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
